// File: rtl/pad_ring_pkg.sv
// Shared types and constants for the programmable pad-ring controller.
package pad_ring_pkg;

    typedef enum logic [1:0] {
        FUNC_GPIO    = 2'd0,
        FUNC_UART_TX = 2'd1,
        FUNC_UART_RX = 2'd2,
        FUNC_OFF     = 2'd3
    } func_e;

    // bit0 is set only in ACTIVE, so software can poll STATUS[0] for "pads live"
    typedef enum logic [1:0] {
        ST_SAFE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_RAMP   = 2'b10
    } state_e;

    localparam logic [9:0] ADDR_CTRL     = 10'h000;
    localparam logic [9:0] ADDR_STATUS   = 10'h004;
    localparam logic [9:0] ADDR_PAD_BASE = 10'h100;

    localparam int CTRL_RELEASE_BIT    = 0;
    localparam int CTRL_FORCE_SAFE_BIT = 1;

    localparam int PAD_FUNC_LSB = 16;
    localparam int PAD_GSEL_LSB = 18;

    localparam int CFG_HLD_H_N_BIT  = 0;
    localparam int CFG_ENABLE_H_BIT = 1;

    localparam logic [15:0] PAD_DEFAULT_CFG = 16'hC03B;

endpackage

// File: rtl/pad_ring_ctrl_pad_slice.sv
// One pad: PAD register, 2-flop input synchroniser and registered output mux.
module pad_slice
    import pad_ring_pkg::*;
#(
    parameter int                CFG_W       = 16,
    parameter int                NGPIO       = 32,
    parameter int                GSEL_W      = 5,
    parameter logic [CFG_W-1:0]  DEFAULT_CFG = CFG_W'(PAD_DEFAULT_CFG),
    parameter func_e             RESET_FUNC  = FUNC_OFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [CFG_W-1:0]  wdata_cfg,
    input  logic [1:0]        wdata_func,
    input  logic [GSEL_W-1:0] wdata_gsel,
    output logic [31:0]       rdata,
    input  state_e            state,
    input  logic [NGPIO-1:0]  gpio_out,
    input  logic [NGPIO-1:0]  gpio_oe,
    input  logic              uart_tx,
    input  logic              uart_tx_en,
    input  logic              din,
    output logic              dout,
    output logic              oen,
    output logic [CFG_W-1:0]  cfg,
    output logic              din_sync,
    output logic              gpio_drive,
    output logic [GSEL_W-1:0] gsel,
    output logic              rx_sel
);

    // Safe values keep the pad held (hld_h_n=0) with enable_h low; RAMP raises enable_h only.
    localparam logic [CFG_W-1:0] SAFE_CFG = DEFAULT_CFG
        & ~(CFG_W'(1) << CFG_HLD_H_N_BIT) & ~(CFG_W'(1) << CFG_ENABLE_H_BIT);
    localparam logic [CFG_W-1:0] RAMP_CFG = SAFE_CFG | (CFG_W'(1) << CFG_ENABLE_H_BIT);

    logic [CFG_W-1:0]  cfg_q;
    func_e             func_q;
    logic [GSEL_W-1:0] gsel_q;
    logic [1:0]        sync_q;
    logic              gsel_ok;
    logic              active;
    logic [CFG_W-1:0]  cfg_d;
    logic              dout_d;
    logic              oen_d;

    assign gsel_ok    = (32'(gsel_q) < NGPIO);
    assign active     = (state == ST_ACTIVE);
    assign din_sync   = sync_q[1];
    assign gsel       = gsel_q;
    assign gpio_drive = active && (func_q == FUNC_GPIO) && gsel_ok;
    assign rx_sel     = active && (func_q == FUNC_UART_RX);

    // PAD register, writable in any sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q  <= DEFAULT_CFG;
            func_q <= RESET_FUNC;
            gsel_q <= '0;
        end else if (wr) begin
            cfg_q  <= wdata_cfg;
            func_q <= func_e'(wdata_func);
            gsel_q <= wdata_gsel;
        end
    end

    // Register readback word
    always_comb begin
        rdata = '0;
        rdata[CFG_W-1:0] = cfg_q;
        rdata[PAD_FUNC_LSB +: 2] = func_q;
        rdata[PAD_GSEL_LSB +: GSEL_W] = gsel_q;
    end

    // Two-flop synchroniser on the pad input
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], din};
    end

    // Next pad drive: safe values unless the ring is ACTIVE
    always_comb begin
        cfg_d  = SAFE_CFG;
        dout_d = 1'b0;
        oen_d  = 1'b1;
        case (state)
            ST_RAMP: cfg_d = RAMP_CFG;
            ST_ACTIVE: begin
                cfg_d = cfg_q;
                case (func_q)
                    FUNC_GPIO: begin
                        if (gsel_ok) begin
                            dout_d = gpio_out[gsel_q];
                            oen_d  = ~gpio_oe[gsel_q];
                        end
                    end
                    FUNC_UART_TX: begin
                        dout_d = uart_tx;
                        oen_d  = ~uart_tx_en;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg  <= SAFE_CFG;
            dout <= 1'b0;
            oen  <= 1'b1;
        end else begin
            cfg  <= cfg_d;
            dout <= dout_d;
            oen  <= oen_d;
        end
    end

endmodule

// File: rtl/pad_ring_ctrl.sv
// Pad-ring controller top: power-up sequencer, register decode, readback and input reduction.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_SAFE   | all pads held safe; leaves on release or once after reset
//  ST_RAMP   | enable_h raised, dwell SEQ_CYCLES cycles
//  ST_ACTIVE | pads follow their PAD registers
module pad_ring_ctrl
    import pad_ring_pkg::*;
#(
    parameter int               NSIDES       = 4,
    parameter int               NPADS_SIDE   = 9,
    parameter int               CFG_W        = 16,
    parameter int               NGPIO        = 32,
    parameter logic [CFG_W-1:0] DEFAULT_CFG  = CFG_W'(PAD_DEFAULT_CFG),
    parameter int               SEQ_CYCLES   = 64,
    parameter bit               AUTO_RELEASE = 1'b1,
    parameter int               UART_TX_PAD  = 8,
    parameter int               UART_RX_PAD  = 7,
    localparam int              NPADS        = NSIDES * NPADS_SIDE,
    localparam int              GSEL_W       = $clog2(NGPIO)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [9:0]             reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic                   reg_rvalid_o,
    output logic [31:0]            reg_rdata_o,
    input  logic [NGPIO-1:0]       gpio_o,
    input  logic [NGPIO-1:0]       gpio_en_o,
    output logic [NGPIO-1:0]       gpio_i,
    input  logic                   uart_tx_i,
    input  logic                   uart_tx_en_i,
    output logic                   uart_rx_o,
    input  logic [NPADS-1:0]       pad_din_i,
    output logic [NPADS-1:0]       pad_dout_o,
    output logic [NPADS-1:0]       pad_oen_o,
    output logic [NPADS-1:0]       pad_ie_o,
    output logic [NPADS*CFG_W-1:0] pad_cfg_o,
    output logic [1:0]             state_o
);

    localparam int CNT_W = $clog2(SEQ_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              arm_q, arm_d;
    logic              ctrl_wr, do_release, do_force_safe;
    logic [5:0]        pad_idx;
    logic              pad_hit;
    logic [NPADS-1:0]  pad_wr;
    logic [31:0]       pad_word [NPADS];
    logic [NPADS-1:0]  din_sync;
    logic [NPADS-1:0]  gpio_drv;
    logic [NPADS-1:0]  rx_sel;
    logic [GSEL_W-1:0] gsel_v [NPADS];
    logic [31:0]       rdata_d;
    logic              unused_wdata;

    assign unused_wdata  = ^reg_wdata_i[31:PAD_GSEL_LSB+GSEL_W];
    assign ctrl_wr       = reg_req_i && reg_we_i && (reg_addr_i == ADDR_CTRL);
    assign do_release    = ctrl_wr && reg_wdata_i[CTRL_RELEASE_BIT];
    assign do_force_safe = ctrl_wr && reg_wdata_i[CTRL_FORCE_SAFE_BIT];
    assign pad_idx       = reg_addr_i[7:2];
    assign pad_hit       = (reg_addr_i[9:8] == ADDR_PAD_BASE[9:8]) && (reg_addr_i[1:0] == 2'b00)
                           && (int'(pad_idx) < NPADS);
    assign state_o       = state_q;
    assign pad_ie_o      = ~pad_oen_o;

    // Sequencer and RAMP dwell counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_SAFE;
            cnt_q   <= '0;
            arm_q   <= AUTO_RELEASE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
        end
    end

    // Next state; arm_q is the one-shot auto-release left over from reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        case (state_q)
            ST_SAFE: begin
                if (do_release || arm_q) begin
                    state_d = ST_RAMP;
                    cnt_d   = CNT_W'(SEQ_CYCLES - 1);
                    arm_d   = 1'b0;
                end
            end
            ST_RAMP: begin
                if (cnt_q == '0) state_d = ST_ACTIVE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ACTIVE: ;
            default: state_d = ST_SAFE;
        endcase
        if (do_force_safe) begin
            state_d = ST_SAFE;
            arm_d   = 1'b0;
        end
    end

    // Per-pad write strobes
    always_comb begin
        pad_wr = '0;
        for (int p = 0; p < NPADS; p++)
            pad_wr[p] = reg_req_i && reg_we_i && pad_hit && (pad_idx == 6'(p));
    end

    for (genvar p = 0; p < NPADS; p++) begin : g_pad
        localparam func_e RST_FUNC = (p == UART_TX_PAD) ? FUNC_UART_TX :
                                     (p == UART_RX_PAD) ? FUNC_UART_RX : FUNC_OFF;
        pad_slice #(
            .CFG_W       (CFG_W),
            .NGPIO       (NGPIO),
            .GSEL_W      (GSEL_W),
            .DEFAULT_CFG (DEFAULT_CFG),
            .RESET_FUNC  (RST_FUNC)
        ) u_slice (
            .clk        (clk_i),
            .rst        (rst_i),
            .wr         (pad_wr[p]),
            .wdata_cfg  (reg_wdata_i[CFG_W-1:0]),
            .wdata_func (reg_wdata_i[PAD_FUNC_LSB +: 2]),
            .wdata_gsel (reg_wdata_i[PAD_GSEL_LSB +: GSEL_W]),
            .rdata      (pad_word[p]),
            .state      (state_q),
            .gpio_out   (gpio_o),
            .gpio_oe    (gpio_en_o),
            .uart_tx    (uart_tx_i),
            .uart_tx_en (uart_tx_en_i),
            .din        (pad_din_i[p]),
            .dout       (pad_dout_o[p]),
            .oen        (pad_oen_o[p]),
            .cfg        (pad_cfg_o[p*CFG_W +: CFG_W]),
            .din_sync   (din_sync[p]),
            .gpio_drive (gpio_drv[p]),
            .gsel       (gsel_v[p]),
            .rx_sel     (rx_sel[p])
        );
    end

    // Read data mux; writes and unmapped addresses return 0
    always_comb begin
        rdata_d = '0;
        if (!reg_we_i) begin
            if (reg_addr_i == ADDR_STATUS) begin
                rdata_d = {30'b0, state_q};
            end else if (pad_hit) begin
                for (int p = 0; p < NPADS; p++)
                    if (pad_idx == 6'(p)) rdata_d = pad_word[p];
            end
        end
    end

    // Register response, one cycle after every request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= reg_req_i ? rdata_d : 32'h0;
        end
    end

    // Input reduction: walk high to low so the lowest-index pad wins
    always_comb begin
        gpio_i    = '0;
        uart_rx_o = 1'b1;
        for (int p = NPADS - 1; p >= 0; p--) begin
            if (gpio_drv[p]) gpio_i[gsel_v[p]] = din_sync[p];
            if (rx_sel[p])   uart_rx_o         = din_sync[p];
        end
    end

endmodule

// File: tb/tb_pad_ring_ctrl.sv
// Directed bench for pad_ring_ctrl with a register-response scoreboard.
module tb_pad_ring_ctrl;
    import pad_ring_pkg::*;

    localparam int NPADS = 36;
    localparam int CFG_W = 16;
    localparam int NGPIO = 32;
    localparam logic [15:0] CFG_DEF  = 16'hC03B;
    localparam logic [15:0] CFG_SAFE = 16'hC038;
    localparam logic [15:0] CFG_RAMP = 16'hC03A;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   reg_req_i, reg_we_i;
    logic [9:0]             reg_addr_i;
    logic [31:0]            reg_wdata_i;
    logic                   reg_rvalid_o;
    logic [31:0]            reg_rdata_o;
    logic [NGPIO-1:0]       gpio_o, gpio_en_o, gpio_i;
    logic                   uart_tx_i, uart_tx_en_i, uart_rx_o;
    logic [NPADS-1:0]       pad_din_i, pad_dout_o, pad_oen_o, pad_ie_o;
    logic [NPADS*CFG_W-1:0] pad_cfg_o;
    logic [1:0]             state_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pad_ring_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o),
        .gpio_o       (gpio_o),
        .gpio_en_o    (gpio_en_o),
        .gpio_i       (gpio_i),
        .uart_tx_i    (uart_tx_i),
        .uart_tx_en_i (uart_tx_en_i),
        .uart_rx_o    (uart_rx_o),
        .pad_din_i    (pad_din_i),
        .pad_dout_o   (pad_dout_o),
        .pad_oen_o    (pad_oen_o),
        .pad_ie_o     (pad_ie_o),
        .pad_cfg_o    (pad_cfg_o),
        .state_o      (state_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cfg_of(input int p);
        return pad_cfg_o[p*CFG_W +: CFG_W];
    endfunction

    task automatic reg_write(input logic [9:0] a, input logic [31:0] d);
        exp_q.push_back(32'h0);
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
        step();
        reg_req_i = 1'b0; reg_we_i = 1'b0;
        check("wr_rvalid", 64'(reg_rvalid_o), 64'd1);
        check("wr_rdata", 64'(reg_rdata_o), 64'(exp_q.pop_front()));
    endtask

    task automatic reg_read(input string tag, input logic [9:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
        step();
        reg_req_i = 1'b0;
        check({tag, "_rvalid"}, 64'(reg_rvalid_o), 64'd1);
        check(tag, 64'(reg_rdata_o), 64'(exp_q.pop_front()));
    endtask

    // Counts RAMP cycles (bounded) and how many showed state bit0 set
    task automatic wait_ramp(output int n, output int bit0_hi);
        n = 0;
        bit0_hi = 0;
        while (state_o == ST_RAMP && n < 200) begin
            if (state_o[0]) bit0_hi++;
            if (n == 2) check("ramp_cfg5", 64'(cfg_of(5)), 64'(CFG_RAMP));
            step();
            n++;
        end
    endtask

    initial begin
        int n, hi, cnt;

        rst_i = 1'b1; reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        gpio_o = '0; gpio_en_o = '0; uart_tx_i = 1'b0; uart_tx_en_i = 1'b0; pad_din_i = '0;
        step();
        step();

        check("rst_state", 64'(state_o), 64'(ST_SAFE));
        check("rst_oen", 64'(pad_oen_o), 64'({NPADS{1'b1}}));
        check("rst_ie", 64'(pad_ie_o), 64'd0);
        check("rst_dout", 64'(pad_dout_o), 64'd0);
        cnt = 0;
        for (int p = 0; p < NPADS; p++) if (cfg_of(p) !== CFG_SAFE) cnt++;
        check("rst_cfg_bad_pads", 64'(cnt), 64'd0);
        check("rst_gpio_i", 64'(gpio_i), 64'd0);
        check("rst_uart_rx", 64'(uart_rx_o), 64'd1);
        check("rst_rvalid", 64'(reg_rvalid_o), 64'd0);
        check("rst_rdata", 64'(reg_rdata_o), 64'd0);

        // Auto release: one SAFE cycle, SEQ_CYCLES of RAMP, then ACTIVE
        uart_tx_i = 1'b1; uart_tx_en_i = 1'b1;
        rst_i = 1'b0;
        check("safe_after_rst", 64'(state_o), 64'(ST_SAFE));
        step();
        check("ramp_entry", 64'(state_o), 64'(ST_RAMP));
        wait_ramp(n, hi);
        check("ramp_cycles", 64'(n), 64'd64);
        check("ramp_bit0_hi", 64'(hi), 64'd0);
        check("active_state", 64'(state_o), 64'(ST_ACTIVE));
        check("uart_rx_active", 64'(uart_rx_o), 64'd0);
        step();
        check("tx_dout8", 64'(pad_dout_o[8]), 64'd1);
        check("tx_oen8", 64'(pad_oen_o[8]), 64'd0);
        check("tx_ie8", 64'(pad_ie_o[8]), 64'd1);
        check("cfg8_active", 64'(cfg_of(8)), 64'(CFG_DEF));
        check("oen0_off", 64'(pad_oen_o[0]), 64'd1);

        reg_read("status_active", ADDR_STATUS, 32'(ST_ACTIVE));
        reg_read("pad8_rst", 10'h120, 32'h0001_C03B);
        reg_read("pad7_rst", 10'h11C, 32'h0002_C03B);
        reg_read("pad0_rst", 10'h100, 32'h0003_C03B);
        reg_read("pad36_none", 10'h190, 32'h0);
        reg_read("ctrl_rd", ADDR_CTRL, 32'h0);
        reg_read("misaligned", 10'h151, 32'h0);
        check("rvalid_drop", 64'(reg_rvalid_o), 64'd1);
        step();
        check("rvalid_low", 64'(reg_rvalid_o), 64'd0);

        // UART RX path: two-cycle synchroniser latency
        pad_din_i[7] = 1'b1;
        step();
        check("rx_lat1", 64'(uart_rx_o), 64'd0);
        step();
        check("rx_lat2", 64'(uart_rx_o), 64'd1);

        // PAD[20] as GPIO 15
        gpio_o[15] = 1'b1; gpio_en_o[15] = 1'b1;
        reg_write(10'h150, 32'h003C_A5C3);
        check("p20_old_oen", 64'(pad_oen_o[20]), 64'd1);
        step();
        check("p20_dout", 64'(pad_dout_o[20]), 64'd1);
        check("p20_oen", 64'(pad_oen_o[20]), 64'd0);
        check("p20_ie", 64'(pad_ie_o[20]), 64'd1);
        check("p20_cfg", 64'(cfg_of(20)), 64'h0000_A5C3);
        reg_read("p20_rd", 10'h150, 32'h003C_A5C3);
        pad_din_i[20] = 1'b1;
        step();
        check("gpio15_lat1", 64'(gpio_i[15]), 64'd0);
        step();
        check("gpio15_lat2", 64'(gpio_i[15]), 64'd1);
        gpio_en_o[15] = 1'b0;
        step();
        check("p20_oen_off", 64'(pad_oen_o[20]), 64'd1);

        // Two pads on GPIO 4: lowest index wins
        reg_write(10'h10C, 32'h0010_C03B);
        reg_write(10'h178, 32'h0010_C03B);
        pad_din_i[3] = 1'b0; pad_din_i[30] = 1'b1;
        step();
        step();
        check("gpio4_low_wins0", 64'(gpio_i[4]), 64'd0);
        pad_din_i[3] = 1'b1; pad_din_i[30] = 1'b0;
        step();
        step();
        check("gpio4_low_wins1", 64'(gpio_i[4]), 64'd1);

        // Force safe beats release
        pad_din_i[7] = 1'b0;
        step();
        step();
        check("rx_before_safe", 64'(uart_rx_o), 64'd0);
        reg_write(ADDR_CTRL, 32'h3);
        check("force_state", 64'(state_o), 64'(ST_SAFE));
        check("force_uart_rx", 64'(uart_rx_o), 64'd1);
        check("force_gpio_i", 64'(gpio_i), 64'd0);
        step();
        check("force_oen", 64'(pad_oen_o), 64'({NPADS{1'b1}}));
        check("force_dout", 64'(pad_dout_o), 64'd0);
        cnt = 0;
        for (int p = 0; p < NPADS; p++) if (cfg_of(p) !== CFG_SAFE) cnt++;
        check("force_cfg_bad_pads", 64'(cnt), 64'd0);
        step(); step(); step();
        check("safe_holds", 64'(state_o), 64'(ST_SAFE));

        // PAD writes in SAFE land in the register but not on the pad
        reg_write(10'h128, 32'h003C_1111);
        step();
        check("safe_wr_cfg10", 64'(cfg_of(10)), 64'(CFG_SAFE));
        reg_read("safe_wr_rd10", 10'h128, 32'h003C_1111);

        // Release, then reset mid-RAMP restarts the sequence
        reg_write(ADDR_CTRL, 32'h1);
        check("release_state", 64'(state_o), 64'(ST_RAMP));
        for (int i = 0; i < 10; i++) step();
        check("mid_ramp_state", 64'(state_o), 64'(ST_RAMP));
        check("mid_ramp_cfg5", 64'(cfg_of(5)), 64'(CFG_RAMP));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_mid_state", 64'(state_o), 64'(ST_SAFE));
        check("rst_mid_cfg5", 64'(cfg_of(5)), 64'(CFG_SAFE));
        step();
        check("re_ramp_entry", 64'(state_o), 64'(ST_RAMP));
        wait_ramp(n, hi);
        check("re_ramp_cycles", 64'(n), 64'd64);
        check("re_active", 64'(state_o), 64'(ST_ACTIVE));
        reg_read("p20_after_rst", 10'h150, 32'h0003_C03B);

        // Release while ACTIVE has no effect
        reg_write(ADDR_CTRL, 32'h1);
        check("release_in_active", 64'(state_o), 64'(ST_ACTIVE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
